// File: rtl/fb_port_arbiter.sv
// Frame-buffer RAM port arbiter: VGA reads take priority, renderer writes and dump reads
// share the remaining cycles round-robin, and a freeze handshake parks writes at a frame boundary.
module fb_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_vld,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_eof,
    output logic              wr_gnt,
    input  logic              dmp_req,
    input  logic [ADDR_W-1:0] dmp_addr,
    output logic              dmp_gnt,
    output logic [DATA_W-1:0] dmp_data,
    output logic              dmp_vld,
    input  logic              frz_req,
    output logic              frz_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } frz_state_t;

    frz_state_t state_r;
    frz_state_t state_next_s;
    logic       rr_dmp_r;       // set: dump side wins the next wr/dmp tie
    logic       vga_gnt_s;
    logic       wr_gnt_s;
    logic       dmp_gnt_s;
    logic       wr_elig_s;
    logic       vga_vld_r;
    logic       dmp_vld_r;
    logic       frz_ack_r;

    // Grant selection; nothing is granted while clr is asserted.
    always_comb begin
        vga_gnt_s = 1'b0;
        wr_gnt_s  = 1'b0;
        dmp_gnt_s = 1'b0;
        wr_elig_s = wr_req && (state_r != FROZEN);
        if (clr) begin
            vga_gnt_s = 1'b0;
        end else if (vga_req) begin
            vga_gnt_s = 1'b1;
        end else if (wr_elig_s && dmp_req) begin
            wr_gnt_s  = ~rr_dmp_r;
            dmp_gnt_s = rr_dmp_r;
        end else if (wr_elig_s) begin
            wr_gnt_s = 1'b1;
        end else if (dmp_req) begin
            dmp_gnt_s = 1'b1;
        end else begin
            dmp_gnt_s = 1'b0;
        end
    end

    // RAM command mux driven by the single winner.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (vga_gnt_s) begin
            mem_addr = vga_addr;
        end else if (wr_gnt_s) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (dmp_gnt_s) begin
            mem_addr = dmp_addr;
        end else begin
            mem_addr = {ADDR_W{1'b0}};
        end
    end

    assign wr_gnt  = wr_gnt_s;
    assign dmp_gnt = dmp_gnt_s;
    assign mem_en  = vga_gnt_s | wr_gnt_s | dmp_gnt_s;
    assign mem_we  = wr_gnt_s;

    // Freeze next-state; a release request overrides an end-of-frame write in the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (frz_req) state_next_s = DRAIN;
                else         state_next_s = RUN;
            end
            DRAIN: begin
                if (!frz_req)                 state_next_s = RUN;
                else if (wr_gnt_s && wr_eof)  state_next_s = FROZEN;
                else                          state_next_s = DRAIN;
            end
            FROZEN: begin
                if (!frz_req) state_next_s = RUN;
                else          state_next_s = FROZEN;
            end
            default: state_next_s = RUN;
        endcase
    end

    // Freeze state, tie pointer, read-valid flags and freeze acknowledge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= RUN;
            rr_dmp_r  <= 1'b0;
            vga_vld_r <= 1'b0;
            dmp_vld_r <= 1'b0;
            frz_ack_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            vga_vld_r <= vga_gnt_s;
            dmp_vld_r <= dmp_gnt_s;
            frz_ack_r <= (state_next_s == FROZEN);
            if (wr_gnt_s) begin
                rr_dmp_r <= 1'b1;
            end else if (dmp_gnt_s) begin
                rr_dmp_r <= 1'b0;
            end else begin
                rr_dmp_r <= rr_dmp_r;
            end
        end
    end

    // Read data is routed to whichever requester owned the previous cycle.
    always_comb begin
        vga_data = {DATA_W{1'b0}};
        dmp_data = {DATA_W{1'b0}};
        if (vga_vld_r) begin
            vga_data = mem_rdata;
        end else if (dmp_vld_r) begin
            dmp_data = mem_rdata;
        end else begin
            vga_data = {DATA_W{1'b0}};
        end
    end

    assign vga_vld = vga_vld_r;
    assign dmp_vld = dmp_vld_r;
    assign frz_ack = frz_ack_r;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: a directed vector table, hand sequences for reset/freeze/read-after-write,
// and random traffic, all checked against a cycle-level reference model with its own shadow frame buffer.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        vga_req, wr_req, wr_eof, dmp_req, frz_req;
    logic [15:0] vga_addr, wr_addr, dmp_addr;
    logic [2:0]  wr_data;
    logic [2:0]  vga_data, dmp_data, mem_wdata, mem_rdata;
    logic        vga_vld, wr_gnt, dmp_gnt, dmp_vld, frz_ack, mem_en, mem_we;
    logic [15:0] mem_addr;

    always #5 clk = ~clk;

    fb_port_arbiter #(.ADDR_W(16), .DATA_W(3)) dut (
        .clk(clk), .clr(clr),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_vld(vga_vld),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_eof(wr_eof), .wr_gnt(wr_gnt),
        .dmp_req(dmp_req), .dmp_addr(dmp_addr), .dmp_gnt(dmp_gnt), .dmp_data(dmp_data), .dmp_vld(dmp_vld),
        .frz_req(frz_req), .frz_ack(frz_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port RAM with 1-cycle read latency (low 11 address bits are enough for this bench).
    logic [2:0] ram [0:2047];
    logic       ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 3'd0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[10:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[10:0]];
        end
    end

    typedef struct {
        logic        vr;
        logic [15:0] va;
        logic        wr;
        logic [15:0] wa;
        logic [2:0]  wd;
        logic        weof;
        logic        dr;
        logic [15:0] da;
        logic        fz;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  e_wr;
        logic  e_dmp;
        logic  e_ack;
        logic  e_vvld;
        logic  e_dvld;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: what the outside world should see, not how the RTL stores it.
    logic       m_frozen, m_draining, m_wr_turn, m_vga_v, m_dmp_v;
    logic [2:0] m_vga_d, m_dmp_d;
    logic [2:0] shadow [0:2047];

    logic       o_wr_gnt, o_dmp_gnt, o_frz_ack, o_dmp_vld;
    logic [2:0] o_dmp_data;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frozen = 1'b0; m_draining = 1'b0; m_wr_turn = 1'b1;
        m_vga_v = 1'b0; m_dmp_v = 1'b0; m_vga_d = 3'd0; m_dmp_d = 3'd0;
    endtask

    task automatic drive(input stim_t s);
        vga_req = s.vr; vga_addr = s.va;
        wr_req = s.wr; wr_addr = s.wa; wr_data = s.wd; wr_eof = s.weof;
        dmp_req = s.dr; dmp_addr = s.da; frz_req = s.fz;
    endtask

    function automatic stim_t mk(input logic vr, input logic wr, input logic dr,
                                 input logic weof, input logic fz, input int i);
        stim_t s;
        s.vr = vr; s.va = 16'(i * 5);
        s.wr = wr; s.wa = 16'(32 + i); s.wd = 3'(i); s.weof = weof;
        s.dr = dr; s.da = 16'(30 + i); s.fz = fz;
        return s;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance the model, return at posedge+1.
    task automatic cycle(input stim_t s);
        logic        g_vga, g_wr, g_dmp, wr_ok;
        logic [15:0] e_addr;
        logic [2:0]  e_wdata;
        drive(s);
        @(negedge clk);
        wr_ok = s.wr && !m_frozen;
        g_vga = s.vr;
        g_wr  = !s.vr && wr_ok && (!s.dr || m_wr_turn);
        g_dmp = !s.vr && !g_wr && s.dr;
        e_addr  = g_vga ? s.va : (g_wr ? s.wa : (g_dmp ? s.da : 16'd0));
        e_wdata = g_wr ? s.wd : 3'd0;
        chk("wr_gnt",    16'(wr_gnt),    16'(g_wr));
        chk("dmp_gnt",   16'(dmp_gnt),   16'(g_dmp));
        chk("mem_en",    16'(mem_en),    16'(g_vga | g_wr | g_dmp));
        chk("mem_we",    16'(mem_we),    16'(g_wr));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", 16'(mem_wdata), 16'(e_wdata));
        chk("vga_vld",   16'(vga_vld),   16'(m_vga_v));
        chk("vga_data",  16'(vga_data),  16'(m_vga_v ? m_vga_d : 3'd0));
        chk("dmp_vld",   16'(dmp_vld),   16'(m_dmp_v));
        chk("dmp_data",  16'(dmp_data),  16'(m_dmp_v ? m_dmp_d : 3'd0));
        chk("frz_ack",   16'(frz_ack),   16'(m_frozen));
        o_wr_gnt = wr_gnt; o_dmp_gnt = dmp_gnt; o_frz_ack = frz_ack;
        o_dmp_vld = dmp_vld; o_dmp_data = dmp_data;
        m_vga_v = g_vga; m_vga_d = shadow[s.va[10:0]];
        m_dmp_v = g_dmp; m_dmp_d = shadow[s.da[10:0]];
        if (g_wr)  begin shadow[s.wa[10:0]] = s.wd; m_wr_turn = 1'b0; end
        if (g_dmp) m_wr_turn = 1'b1;
        if (!s.fz) begin
            m_frozen = 1'b0; m_draining = 1'b0;
        end else if (m_draining) begin
            if (g_wr && s.weof) begin m_frozen = 1'b1; m_draining = 1'b0; end
        end else if (!m_frozen) begin
            m_draining = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    // Assert clr with requests still active: every output must drop at once.
    task automatic do_reset(input stim_t s);
        drive(s);
        clr = 1'b1;
        #1;
        chk("rst_wr_gnt",  16'(wr_gnt),  16'd0);
        chk("rst_dmp_gnt", 16'(dmp_gnt), 16'd0);
        chk("rst_mem_en",  16'(mem_en),  16'd0);
        chk("rst_mem_we",  16'(mem_we),  16'd0);
        chk("rst_mem_addr", mem_addr,    16'd0);
        chk("rst_vga_vld", 16'(vga_vld), 16'd0);
        chk("rst_vga_data", 16'(vga_data), 16'd0);
        chk("rst_dmp_vld", 16'(dmp_vld), 16'd0);
        chk("rst_frz_ack", 16'(frz_ack), 16'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        stim_t s;
        logic  fz_lvl;
        clr = 1'b1; ram_clr = 1'b1;
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        for (int i = 0; i < 2048; i++) shadow[i] = 3'd0;
        model_reset();

        //         vr    wr    dr    eof   fz       e_wr  e_dmp e_ack e_vvld e_dvld
        tbl[0]  = '{mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0),  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1),  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2),  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3),  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4),  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5),  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6),  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 13), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        @(posedge clk); #1;
        ram_clr = 1'b0;
        clr = 1'b0;

        // Leave the tie pointer favouring dump with a VGA read in flight, then reset mid-transfer.
        cycle(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40));
        cycle(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 41));
        do_reset(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 42));

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].s);
            chk("tbl_wr_gnt",  16'(o_wr_gnt),  16'(tbl[i].e_wr));
            chk("tbl_dmp_gnt", 16'(o_dmp_gnt), 16'(tbl[i].e_dmp));
            chk("tbl_frz_ack", 16'(o_frz_ack), 16'(tbl[i].e_ack));
            chk("tbl_dmp_vld", 16'(o_dmp_vld), 16'(tbl[i].e_dvld));
            chk("tbl_vga_vld", 16'(vga_vld === 1'bx ? 1'b0 : m_vga_v), 16'(m_vga_v));
        end

        // Freeze: write a 100-pixel frame, eof on the last pixel, then dump it with writes held off.
        for (int a = 0; a < 100; a++) begin
            s = mk(1'b0, 1'b1, 1'b0, (a == 99), 1'b1, 0);
            s.wa = 16'(a); s.wd = 3'((a * 3) % 8);
            cycle(s);
        end
        for (int a = 0; a < 100; a++) begin
            s = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
            s.wa = 16'd500; s.wd = 3'd7; s.da = 16'(a);
            cycle(s);
            chk("frz_wr_blocked", 16'(o_wr_gnt), 16'd0);
            chk("frz_ack_hold",   16'(o_frz_ack), 16'd1);
            if (a > 0) chk("frz_dump_data", 16'(o_dmp_data), 16'(((a - 1) * 3) % 8));
        end
        s = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        s.wa = 16'd500; s.wd = 3'd7;
        cycle(s);
        chk("frz_last_data",   16'(o_dmp_data), 16'd1);
        chk("frz_release_hold", 16'(o_wr_gnt),  16'd0);
        cycle(s);
        chk("frz_release_resume", 16'(o_wr_gnt), 16'd1);
        chk("frz_release_ack",    16'(o_frz_ack), 16'd0);

        // Read-after-write through the dump port.
        s = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        s.wa = 16'd1234; s.wd = 3'b101;
        cycle(s);
        s = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        s.da = 16'd1234;
        cycle(s);
        cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        chk("raw_dmp_vld",  16'(o_dmp_vld),  16'd1);
        chk("raw_dmp_data", 16'(o_dmp_data), 16'd5);

        // Random traffic with a slowly toggling freeze request.
        fz_lvl = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) fz_lvl = ~fz_lvl;
            s.vr   = ($urandom_range(0, 3) == 0);
            s.va   = 16'($urandom_range(0, 255));
            s.wr   = 1'($urandom_range(0, 1));
            s.wa   = 16'($urandom_range(0, 255));
            s.wd   = 3'($urandom_range(0, 7));
            s.weof = ($urandom_range(0, 5) == 0);
            s.dr   = 1'($urandom_range(0, 1));
            s.da   = 16'($urandom_range(0, 255));
            s.fz   = fz_lvl;
            cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
